ddr_test_regs_n: RTL and testbench
==================================

# ddr_test_regs_n

Parametrised register file that controls NCH DDR test engines from the host register bus. It replaces the fixed four-channel DDR test register bank. Control is pulse-based: start is a self-clearing pulse, error and done flags are sticky write-1-to-clear, and an interrupt is raised on test completion. Size and address registers are locked while their channel is busy. It sits between the host register-bus slave and the per-channel DDR traffic generators/checkers.

## Interface
Parameters:
- NCH, 4, number of DDR test channels (1..15)
- AW, 8, register-bus byte-address width; word address is ADR[AW-1:2]
- VERSION, 32'h2022_0101, value returned at word 0x00

Ports:
- CLK  in  1  single clock for all logic
- RST_N  in  1  reset, synchronous and active-low
- REG_WREN  in  1  write strobe, one word per cycle
- REG_WADR  in  AW  write byte address
- REG_WDAT  in  32  write data
- REG_RDEN  in  1  read request (level; rising edge starts a read)
- REG_RADR  in  AW  read byte address, stable while REG_RDEN high
- REG_RDAT  out  32  read data
- REG_RVLD  out  1  one-cycle read-valid pulse
- DDR_INIT_DONE  in  NCH  per-channel calibration done
- TEST_START  out  NCH  one-cycle start pulse per channel
- TEST_MODE  out  NCH  0 = single pass, 1 = continuous
- TEST_SIZE  out  32*NCH  test length, channel c at [32c+31:32c]
- TEST_ADDR  out  32*NCH  test base address
- TEST_BUSY  in  2*NCH  per-channel busy (write/read phase); nonzero means busy
- TEST_ERR  in  NCH  compare-error level
- TEST_CASE  in  2*NCH  current pattern case
- TEST_WTIME, TEST_RTIME  in  32*NCH  write/read time counters
- IRQ  out  1  level interrupt

## Operation
- Word map: 0x00 VERSION (RO); 0x01 STATUS = DDR_INIT_DONE zero-extended (RO); 0x02 IRQ_STAT [NCH-1:0] (W1C); 0x03 IRQ_EN (RW).
- Channel c window at base 8*(c+1): +0 CTRL, +1 SIZE (RW), +2 ADDR (RW), +3 WTIME (RO), +4 RTIME (RO), +5 ERRCNT, +6/+7 read 0.
- CTRL bits:
  - [0] START: W1 pulses TEST_START; reads 0.
  - [1] MODE (RW).
  - [5:4] BUSY (RO).
  - [8] ERR: sticky, set on TEST_ERR high, W1C.
  - [13:12] CASE (RO).
  - [16] DONE: sticky, set on BUSY nonzero→zero, W1C.
- A DONE set also sets IRQ_STAT[c]. IRQ = |(IRQ_STAT & IRQ_EN[NCH-1:0]), registered.
- Busy lock: while TEST_BUSY of channel c is nonzero, writes to SIZE/ADDR/MODE and START=1 are dropped silently. W1C of ERR/DONE is still honoured.
- Writes to RO words, words beyond the last channel, and unmapped words are ignored. Reads of these return 32'h0.
- A hardware set and a W1C in the same cycle: the set wins and the bit remains 1.
- BUSY, ERR and CASE are sampled into registers each cycle (one-cycle delay) before detection and readback.

## Timing
- Write path: bus inputs are registered, then applied on the next edge. A write presented at cycle t is visible in the register or outputs at t+2. TEST_START is high during cycle t+2 only.
- Read path: address is decoded and data captured in the cycle REG_RDEN is first sampled high (t). REG_RDAT is valid and REG_RVLD pulses high for exactly one cycle at t+3. REG_RDAT holds its value until the next read.
- Holding REG_RDEN high produces a single RVLD; each new read requires REG_RDEN to return low for at least one cycle.
- Back-to-back writes are accepted every cycle. A read and a write in the same cycle to the same word return the old value.
- Reset values (RST_N low at an edge): all RW/sticky registers 0; TEST_START, TEST_MODE, TEST_SIZE, TEST_ADDR, IRQ, REG_RDAT, REG_RVLD all 0.
- Reset mid-read: the pending RVLD is cancelled. Reset mid-test: TEST_MODE forced to 0, and no DONE is generated from the reset-induced busy drop.

## Configuration
- DDR_REG_ERRCNT_EN defined: per-channel 32-bit ERRCNT at +5 counts rising edges of sampled TEST_ERR and saturates at 32'hFFFF_FFFF. A write of any value clears it; a simultaneous increment is lost (clear wins).
- DDR_REG_ERRCNT_EN undefined: no counter logic; +5 reads 0 and writes are ignored.

## Structure
- Package ddr_reg_pkg holds:
  - Word-offset constants for global and channel-relative registers, channel stride 8, CTRL bit positions.
  - Default VERSION.
  - A packed ctrl_t typedef for CTRL.
- Sub-module ddr_reg_chan, instantiated NCH times by generate, holds per-channel:
  - SIZE/ADDR/MODE registers and the busy lock.
  - START pulse, ERR/DONE sticky bits and busy-edge detect.
  - Optional ERRCNT and the channel readback mux.
- The top level keeps bus registration, global registers, the IRQ reduction and the read pipeline.

## Test plan
- Reset, then read 0x00, 0x01 with DDR_INIT_DONE=4'b0101 → 32'h2022_0101 then 32'h5, each RVLD exactly 3 cycles after the RDEN rise.
- Write ch1 SIZE=32'h0010_0000 and ADDR=32'h4000_0000, then write CTRL=0x3 → TEST_MODE[1]=1 and a single TEST_START[1] pulse 2 cycles after the write.
- Hold TEST_BUSY[3:2]=2'b01, write SIZE=0x1234 to ch1 → readback is still 32'h0010_0000, and START is suppressed.
- Drop ch1 busy to 0 with IRQ_EN=0x2 → CTRL[16]=1, IRQ_STAT=0x2, IRQ=1. Write IRQ_STAT=0x2 and CTRL=0x1_0000 → IRQ=0.
- Pulse TEST_ERR[0] three times → CTRL0[8]=1, ERRCNT0=3 (macro on) or 0 (macro off). W1C of ERR coincident with a new error pulse → ERR stays 1.
- Read 0x2F (beyond the NCH=4 window) → 32'h0. Assert RST_N low for 1 cycle mid-read → no RVLD, and all outputs return to 0.

Source files
------------

// File: rtl/ddr_reg_pkg.sv
// ddr_reg_pkg: shared constants and types for the DDR test register file.
//   - Word offsets of the global registers and of the channel-relative
//     registers (channel c window starts at word CH_STRIDE*(c+1)).
//   - CTRL bit positions and the packed ctrl_t readback layout.
//   - Default VERSION value.
package ddr_reg_pkg;

    localparam logic [31:0] DEF_VERSION = 32'h2022_0101;

    // Global words
    localparam int REG_VERSION  = 0;
    localparam int REG_STATUS   = 1;
    localparam int REG_IRQ_STAT = 2;
    localparam int REG_IRQ_EN   = 3;

    // Channel windows
    localparam int CH_STRIDE = 8;
    localparam int CH_SHIFT  = $clog2(CH_STRIDE);

    localparam logic [2:0] CH_CTRL   = 3'd0;
    localparam logic [2:0] CH_SIZE   = 3'd1;
    localparam logic [2:0] CH_ADDR   = 3'd2;
    localparam logic [2:0] CH_WTIME  = 3'd3;
    localparam logic [2:0] CH_RTIME  = 3'd4;
    localparam logic [2:0] CH_ERRCNT = 3'd5;

    // CTRL bit positions
    localparam int CTRL_START = 0;
    localparam int CTRL_MODE  = 1;
    localparam int CTRL_ERR   = 8;
    localparam int CTRL_DONE  = 16;

    typedef struct packed {
        logic [14:0] rsv4;
        logic        done;    // [16]
        logic [1:0]  rsv3;
        logic [1:0]  tcase;   // [13:12]
        logic [2:0]  rsv2;
        logic        err;     // [8]
        logic [1:0]  rsv1;
        logic [1:0]  busy;    // [5:4]
        logic [1:0]  rsv0;
        logic        mode;    // [1]
        logic        start;   // [0], always reads 0
    } ctrl_t;

endpackage

// File: rtl/ddr_reg_chan.sv
// ddr_reg_chan: register slice for one DDR test channel.
//   clk, rst_n        : clock, synchronous active-low reset
//   wr, woff, wdat    : registered write strobe (already decoded to this
//                       channel), word offset within the window, data
//   rd_off, rdat      : combinational readback of the addressed word
//   busy_in, err_in,
//   case_in           : engine status, sampled one cycle before use
//   wtime, rtime      : engine time counters (read-only, passed through)
//   start, mode,
//   size, addr        : engine controls
//   done_set          : one-cycle pulse when the sampled busy falls to zero
// Optional feature: DDR_REG_ERRCNT_EN adds a saturating error-edge counter.
module ddr_reg_chan
    import ddr_reg_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        wr,
    input  logic [2:0]  woff,
    input  logic [31:0] wdat,
    input  logic [2:0]  rd_off,
    input  logic [1:0]  busy_in,
    input  logic        err_in,
    input  logic [1:0]  case_in,
    input  logic [31:0] wtime,
    input  logic [31:0] rtime,
    output logic        start,
    output logic        mode,
    output logic [31:0] size,
    output logic [31:0] addr,
    output logic        done_set,
    output logic [31:0] rdat
);

    logic [1:0]  busy_s, busy_p;
    logic [1:0]  case_s;
    logic        err_s;
    logic        err_flag, done_flag;
    logic        locked;
    logic        wr_ctrl, wr_size, wr_addr;
    logic [31:0] errcnt_rd;
    ctrl_t       ctrl_rd;

    assign wr_ctrl  = wr && (woff == CH_CTRL);
    assign wr_size  = wr && (woff == CH_SIZE);
    assign wr_addr  = wr && (woff == CH_ADDR);
    assign locked   = |busy_s;
    // Busy falling edge; both samples are zero after reset, so a reset never fakes a DONE.
    assign done_set = (|busy_p) && !(|busy_s);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            busy_s    <= '0;
            busy_p    <= '0;
            case_s    <= '0;
            err_s     <= 1'b0;
            start     <= 1'b0;
            mode      <= 1'b0;
            size      <= '0;
            addr      <= '0;
            err_flag  <= 1'b0;
            done_flag <= 1'b0;
        end else begin
            busy_s <= busy_in;
            busy_p <= busy_s;
            case_s <= case_in;
            err_s  <= err_in;
            start  <= wr_ctrl && wdat[CTRL_START] && !locked;
            if (wr_ctrl && !locked) mode <= wdat[CTRL_MODE];
            if (wr_size && !locked) size <= wdat;
            if (wr_addr && !locked) addr <= wdat;
            // Hardware set takes priority over W1C in the same cycle.
            if (err_s)                          err_flag  <= 1'b1;
            else if (wr_ctrl && wdat[CTRL_ERR]) err_flag  <= 1'b0;
            if (done_set)                        done_flag <= 1'b1;
            else if (wr_ctrl && wdat[CTRL_DONE]) done_flag <= 1'b0;
        end
    end

`ifdef DDR_REG_ERRCNT_EN
    logic        err_p;
    logic [31:0] errcnt;
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err_p  <= 1'b0;
            errcnt <= '0;
        end else begin
            err_p <= err_s;
            // Any write clears; a coincident increment is lost.
            if (wr && (woff == CH_ERRCNT))
                errcnt <= '0;
            else if (err_s && !err_p && (errcnt != 32'hFFFF_FFFF))
                errcnt <= errcnt + 32'd1;
        end
    end
    assign errcnt_rd = errcnt;
`else
    assign errcnt_rd = '0;
`endif

    always_comb begin
        ctrl_rd       = '0;
        ctrl_rd.mode  = mode;
        ctrl_rd.busy  = busy_s;
        ctrl_rd.err   = err_flag;
        ctrl_rd.tcase = case_s;
        ctrl_rd.done  = done_flag;
        case (rd_off)
            CH_CTRL:   rdat = ctrl_rd;
            CH_SIZE:   rdat = size;
            CH_ADDR:   rdat = addr;
            CH_WTIME:  rdat = wtime;
            CH_RTIME:  rdat = rtime;
            CH_ERRCNT: rdat = errcnt_rd;
            default:   rdat = '0;
        endcase
    end

endmodule

// File: rtl/ddr_test_regs_n.sv
// ddr_test_regs_n: host register file controlling NCH DDR test engines.
//   CLK, RST_N              : clock, synchronous active-low reset
//   REG_WREN/WADR/WDAT      : write port, one word per cycle, applied 2 cycles later
//   REG_RDEN/RADR           : read request (rising edge of RDEN starts a read)
//   REG_RDAT/RVLD           : read data, valid with a one-cycle RVLD 3 cycles later
//   DDR_INIT_DONE           : calibration status, readable at word 1
//   TEST_*                  : per-channel engine controls and status
//   IRQ                     : level interrupt, |(IRQ_STAT & IRQ_EN)
// Optional feature: DDR_REG_ERRCNT_EN (per-channel error counter at +5).
module ddr_test_regs_n
    import ddr_reg_pkg::*;
#(
    parameter int          NCH     = 4,
    parameter int          AW      = 8,
    parameter logic [31:0] VERSION = DEF_VERSION
) (
    input  logic                CLK,
    input  logic                RST_N,
    input  logic                REG_WREN,
    input  logic [AW-1:0]       REG_WADR,
    input  logic [31:0]         REG_WDAT,
    input  logic                REG_RDEN,
    input  logic [AW-1:0]       REG_RADR,
    output logic [31:0]         REG_RDAT,
    output logic                REG_RVLD,
    input  logic [NCH-1:0]      DDR_INIT_DONE,
    output logic [NCH-1:0]      TEST_START,
    output logic [NCH-1:0]      TEST_MODE,
    output logic [32*NCH-1:0]   TEST_SIZE,
    output logic [32*NCH-1:0]   TEST_ADDR,
    input  logic [2*NCH-1:0]    TEST_BUSY,
    input  logic [NCH-1:0]      TEST_ERR,
    input  logic [2*NCH-1:0]    TEST_CASE,
    input  logic [32*NCH-1:0]   TEST_WTIME,
    input  logic [32*NCH-1:0]   TEST_RTIME,
    output logic                IRQ
);

    localparam int WW = AW - 2;

    logic                  w_en;
    logic [WW-1:0]         w_word;
    logic [31:0]           w_dat;
    logic [WW-1:0]         rd_word;
    logic [NCH-1:0]        irq_stat, irq_en, done_set;
    logic [NCH-1:0][31:0]  ch_rdat;
    logic [31:0]           rd_data, rd_d0, rd_d1;
    logic                  rden_q, rd_start;
    logic [2:0]            vld_pipe;
    logic                  unused_bits;

    assign rd_word     = REG_RADR[AW-1:2];
    assign unused_bits = ^{REG_WADR[1:0], REG_RADR[1:0]};

    // Write port registration.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            w_en   <= 1'b0;
            w_word <= '0;
            w_dat  <= '0;
        end else begin
            w_en   <= REG_WREN;
            w_word <= REG_WADR[AW-1:2];
            w_dat  <= REG_WDAT;
        end
    end

    // Global registers and interrupt.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            irq_stat <= '0;
            irq_en   <= '0;
            IRQ      <= 1'b0;
        end else begin
            if (w_en && (w_word == WW'(REG_IRQ_STAT)))
                irq_stat <= (irq_stat & ~w_dat[NCH-1:0]) | done_set;
            else
                irq_stat <= irq_stat | done_set;
            if (w_en && (w_word == WW'(REG_IRQ_EN)))
                irq_en <= w_dat[NCH-1:0];
            IRQ <= |(irq_stat & irq_en);
        end
    end

    for (genvar c = 0; c < NCH; c++) begin : g_ch
        ddr_reg_chan u_chan (
            .clk      (CLK),
            .rst_n    (RST_N),
            .wr       (w_en && (w_word[WW-1:CH_SHIFT] == (WW-CH_SHIFT)'(c + 1))),
            .woff     (w_word[CH_SHIFT-1:0]),
            .wdat     (w_dat),
            .rd_off   (rd_word[CH_SHIFT-1:0]),
            .busy_in  (TEST_BUSY[2*c +: 2]),
            .err_in   (TEST_ERR[c]),
            .case_in  (TEST_CASE[2*c +: 2]),
            .wtime    (TEST_WTIME[32*c +: 32]),
            .rtime    (TEST_RTIME[32*c +: 32]),
            .start    (TEST_START[c]),
            .mode     (TEST_MODE[c]),
            .size     (TEST_SIZE[32*c +: 32]),
            .addr     (TEST_ADDR[32*c +: 32]),
            .done_set (done_set[c]),
            .rdat     (ch_rdat[c])
        );
    end

    // Read decode: anything not matched (words 4..7, missing channels) reads 0.
    always_comb begin
        rd_data = '0;
        if (rd_word == WW'(REG_VERSION))  rd_data = VERSION;
        if (rd_word == WW'(REG_STATUS))   rd_data = 32'(DDR_INIT_DONE);
        if (rd_word == WW'(REG_IRQ_STAT)) rd_data = 32'(irq_stat);
        if (rd_word == WW'(REG_IRQ_EN))   rd_data = 32'(irq_en);
        for (int c = 0; c < NCH; c++)
            if (rd_word[WW-1:CH_SHIFT] == (WW-CH_SHIFT)'(c + 1)) rd_data = ch_rdat[c];
    end

    // Read pipeline: capture on the RDEN rise, present 3 cycles later.
    assign rd_start = REG_RDEN && !rden_q;
    assign REG_RVLD = vld_pipe[2];

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            // Track the live level so a read held across reset does not retrigger.
            rden_q   <= REG_RDEN;
            vld_pipe <= '0;
            rd_d0    <= '0;
            rd_d1    <= '0;
            REG_RDAT <= '0;
        end else begin
            rden_q   <= REG_RDEN;
            vld_pipe <= {vld_pipe[1:0], rd_start};
            if (rd_start)    rd_d0    <= rd_data;
            if (vld_pipe[0]) rd_d1    <= rd_d0;
            if (vld_pipe[1]) REG_RDAT <= rd_d1;
        end
    end

endmodule

// File: tb/tb_ddr_test_regs_n.sv
module tb_ddr_test_regs_n;

    logic         CLK = 1'b0;
    logic         RST_N = 1'b0;
    logic         REG_WREN = 1'b0;
    logic [7:0]   REG_WADR = '0;
    logic [31:0]  REG_WDAT = '0;
    logic         REG_RDEN = 1'b0;
    logic [7:0]   REG_RADR = '0;
    logic [31:0]  REG_RDAT;
    logic         REG_RVLD;
    logic [3:0]   DDR_INIT_DONE = '0;
    logic [3:0]   TEST_START;
    logic [3:0]   TEST_MODE;
    logic [127:0] TEST_SIZE;
    logic [127:0] TEST_ADDR;
    logic [7:0]   TEST_BUSY = '0;
    logic [3:0]   TEST_ERR = '0;
    logic [7:0]   TEST_CASE = '0;
    logic [127:0] TEST_WTIME = '0;
    logic [127:0] TEST_RTIME = '0;
    logic         IRQ;

    int total = 0;
    int bad = 0;

`ifdef DDR_REG_ERRCNT_EN
    localparam logic [31:0] EXP_ECNT = 32'd3;
`else
    localparam logic [31:0] EXP_ECNT = 32'd0;
`endif

    ddr_test_regs_n dut (
        .CLK(CLK), .RST_N(RST_N),
        .REG_WREN(REG_WREN), .REG_WADR(REG_WADR), .REG_WDAT(REG_WDAT),
        .REG_RDEN(REG_RDEN), .REG_RADR(REG_RADR),
        .REG_RDAT(REG_RDAT), .REG_RVLD(REG_RVLD),
        .DDR_INIT_DONE(DDR_INIT_DONE),
        .TEST_START(TEST_START), .TEST_MODE(TEST_MODE),
        .TEST_SIZE(TEST_SIZE), .TEST_ADDR(TEST_ADDR),
        .TEST_BUSY(TEST_BUSY), .TEST_ERR(TEST_ERR), .TEST_CASE(TEST_CASE),
        .TEST_WTIME(TEST_WTIME), .TEST_RTIME(TEST_RTIME),
        .IRQ(IRQ)
    );

    always #5 CLK = ~CLK;

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [7:0] a, input logic [31:0] d);
        REG_WREN = 1'b1;
        REG_WADR = a;
        REG_WDAT = d;
        step();
        REG_WREN = 1'b0;
    endtask

    // Starts a read (any write already on the bus goes in the same cycle),
    // checks latency, data, single RVLD while RDEN is held, and data hold.
    task automatic rd(input string tag, input logic [7:0] a, input logic [31:0] exp);
        int lat;
        logic [31:0] d;
        REG_RDEN = 1'b1;
        REG_RADR = a;
        lat = 0;
        for (int i = 1; i <= 10; i++) begin
            step();
            if (i == 1) REG_WREN = 1'b0;
            if (REG_RVLD) begin
                lat = i;
                break;
            end
        end
        d = REG_RDAT;
        chk({tag, "_lat"}, 64'(lat), 64'd3);
        chk(tag, 64'(d), 64'(exp));
        step();
        chk({tag, "_single"}, 64'(REG_RVLD), 64'd0);
        chk({tag, "_hold"}, 64'(REG_RDAT), 64'(exp));
        REG_RDEN = 1'b0;
        step();
    endtask

    initial begin
        logic       seen;
        // Reset state
        step();
        step();
        chk("rst_start", 64'(TEST_START), 64'd0);
        chk("rst_mode", 64'(TEST_MODE), 64'd0);
        chk("rst_size", 64'(|TEST_SIZE), 64'd0);
        chk("rst_addr", 64'(|TEST_ADDR), 64'd0);
        chk("rst_irq_rd", {REG_RDAT, 31'd0, IRQ}, 64'd0);
        chk("rst_rvld", 64'(REG_RVLD), 64'd0);
        RST_N = 1'b1;
        DDR_INIT_DONE = 4'b0101;
        step();

        rd("version", 8'h00, 32'h2022_0101);
        rd("status", 8'h04, 32'h0000_0005);

        // Channel 1 setup and start
        wr(8'h44, 32'h0010_0000);
        wr(8'h48, 32'h4000_0000);
        wr(8'h40, 32'h0000_0003);
        chk("start_early", 64'(TEST_START), 64'd0);
        step();
        chk("start_pulse", 64'(TEST_START), 64'b0010);
        chk("mode1", 64'(TEST_MODE), 64'b0010);
        chk("size1", 64'(TEST_SIZE[63:32]), 64'h0010_0000);
        chk("addr1", 64'(TEST_ADDR[63:32]), 64'h4000_0000);
        step();
        chk("start_end", 64'(TEST_START), 64'd0);

        // Busy lock on channel 1
        TEST_BUSY = 8'b0000_0100;
        TEST_CASE = 8'b0000_1000;
        step();
        step();
        wr(8'h44, 32'h0000_1234);
        wr(8'h40, 32'h0000_0001);
        seen = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            seen = seen | (|TEST_START);
        end
        chk("busy_no_start", 64'(seen), 64'd0);
        rd("busy_size", 8'h44, 32'h0010_0000);
        rd("busy_ctrl", 8'h40, 32'h0000_2012);

        // Completion, DONE and IRQ
        wr(8'h0C, 32'h0000_0002);
        TEST_BUSY = 8'b0;
        for (int i = 0; i < 4; i++) step();
        chk("irq_set", 64'(IRQ), 64'd1);
        rd("done_ctrl", 8'h40, 32'h0001_2002);
        rd("irq_stat", 8'h08, 32'h0000_0002);
        wr(8'h08, 32'h0000_0002);
        wr(8'h40, 32'h0001_0000);
        for (int i = 0; i < 3; i++) step();
        chk("irq_clr", 64'(IRQ), 64'd0);
        chk("mode_clr", 64'(TEST_MODE), 64'd0);
        rd("done_clr", 8'h40, 32'h0000_2000);
        rd("irq_stat_clr", 8'h08, 32'h0000_0000);

        // Errors on channel 0
        for (int i = 0; i < 3; i++) begin
            TEST_ERR = 4'b0001;
            step();
            TEST_ERR = 4'b0000;
            step();
        end
        step();
        rd("err_set", 8'h20, 32'h0000_0100);
        rd("errcnt", 8'h34, EXP_ECNT);
        wr(8'h20, 32'h0000_0100);
        step();
        rd("err_w1c", 8'h20, 32'h0000_0000);
        // W1C lands in the same cycle as a new sampled error
        REG_WREN = 1'b1;
        REG_WADR = 8'h20;
        REG_WDAT = 32'h0000_0100;
        TEST_ERR = 4'b0001;
        step();
        REG_WREN = 1'b0;
        TEST_ERR = 4'b0000;
        step();
        step();
        rd("err_set_wins", 8'h20, 32'h0000_0100);
        wr(8'h34, 32'h0000_DEAD);
        step();
        rd("errcnt_clr", 8'h34, 32'h0000_0000);

        // Same-cycle read and write of one word returns the old value
        REG_WREN = 1'b1;
        REG_WADR = 8'h48;
        REG_WDAT = 32'h5555_0000;
        rd("rw_old", 8'h48, 32'h4000_0000);
        rd("rw_new", 8'h48, 32'h5555_0000);
        chk("addr1_new", 64'(TEST_ADDR[63:32]), 64'h5555_0000);

        // RO and unmapped writes ignored
        TEST_WTIME[63:32] = 32'hABCD_0001;
        wr(8'h00, 32'hFFFF_FFFF);
        wr(8'h4C, 32'h0000_0001);
        wr(8'hBC, 32'h0000_1234);
        step();
        rd("wtime", 8'h4C, 32'hABCD_0001);
        rd("version_ro", 8'h00, 32'h2022_0101);
        rd("beyond", 8'hBC, 32'h0000_0000);
        rd("unmapped", 8'h18, 32'h0000_0000);

        // Reset during a test and mid-read
        wr(8'h40, 32'h0000_0002);
        step();
        chk("mode_pre_rst", 64'(TEST_MODE), 64'b0010);
        rd("status_pre_rst", 8'h04, 32'h0000_0005);
        REG_RDEN = 1'b1;
        REG_RADR = 8'h00;
        step();
        RST_N = 1'b0;
        step();
        RST_N = 1'b1;
        REG_RDEN = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            seen = seen | REG_RVLD;
        end
        chk("rst_no_rvld", 64'(seen), 64'd0);
        chk("rst2_mode", 64'(TEST_MODE), 64'd0);
        chk("rst2_size", 64'(|TEST_SIZE), 64'd0);
        chk("rst2_addr", 64'(|TEST_ADDR), 64'd0);
        chk("rst2_rdat_irq", {REG_RDAT, 27'd0, TEST_START, IRQ}, 64'd0);
        rd("rst2_ctrl", 8'h40, 32'h0000_2000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
